bitwise_accum: RTL

- Streaming, parametrised bitwise reduction unit.
- Accepts a frame of WIDTH-bit words over a valid/ready input and folds them with a selectable bitwise op (OR/AND/XOR/NOR).
- Emits one registered result per frame with all-ones/all-zeros flags.
- Used by the ALU datapath and the Tetris board logic, e.g. row-collision OR and full-row AND across board rows.

---
 rtl/bitwise_accum_pkg.sv | 17 +
 rtl/bitwise_accum_op_slice.sv | 24 ++
 rtl/bitwise_accum.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bitwise_accum_pkg.sv
// Shared op encodings and width helpers for the bitwise reduction blocks.
// Optional popcount output in bitwise_accum is enabled by BITWISE_ACCUM_POPCOUNT_EN.
package bitwise_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    // Bits needed to hold any count in 0..n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bitwise_accum_op_slice.sv
// Combinational two-operand bitwise op; shared with the ALU datapath.
module bitwise_op_slice
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_e              op_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_OR:   y_o = a_i | b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NOR:  y_o = ~(a_i | b_i);
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_accum.sv
// Streaming frame reducer: folds WIDTH-bit beats with OR/AND/XOR/NOR into one registered result.
// Define BITWISE_ACCUM_POPCOUNT_EN to add the out_popcount output.
module bitwise_accum
    import bitwise_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BEATS = 20
) (
    input  logic                                clock,
    input  logic                                reset_n,
    // Handshake: a beat/result transfers on a rising edge where valid and ready are both 1;
    // valid holds with stable data until it transfers, ready may change freely.
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    in_data,
    input  logic [1:0]                          in_op,
    input  logic                                in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WIDTH-1:0]                    out_data,
    output logic                                out_all_ones,
    output logic                                out_all_zeros,
    output logic [cnt_width(MAX_BEATS)-1:0]     out_beats,
`ifdef BITWISE_ACCUM_POPCOUNT_EN
    output logic [cnt_width(WIDTH)-1:0]         out_popcount,
`endif
    output logic                                out_overflow
);

    localparam int CW = cnt_width(MAX_BEATS);
    localparam int PW = cnt_width(WIDTH);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic             first_q, first_d;
    op_e              op_q, op_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             all_ones_q, all_ones_d;
    logic             all_zeros_q, all_zeros_d;
    logic [CW-1:0]    out_beats_q, out_beats_d;
    logic             overflow_q, overflow_d;
    logic [PW-1:0]    pop_q, pop_d;

    logic             accept, close;
    op_e              op_cur, fold_op;
    logic [WIDTH-1:0] fold_y, acc_next, result;
    logic [CW-1:0]    beat_next;

    // NOR accumulates as OR; the inversion is applied only to the closed result.
    assign fold_op = (op_q == OP_NOR) ? OP_OR : op_q;

    bitwise_op_slice #(.WIDTH(WIDTH)) u_slice (
        .a_i  (acc_q),
        .b_i  (in_data),
        .op_i (fold_op),
        .y_o  (fold_y)
    );

    assign in_ready = ~out_valid_q | out_ready;

    always_comb begin
        accept    = in_valid & in_ready;
        op_cur    = first_q ? op_e'(in_op) : op_q;
        acc_next  = first_q ? in_data : fold_y;
        beat_next = first_q ? CW'(1) : beat_cnt_q + CW'(1);
        close     = accept & (in_last | (beat_next == MAX_CNT));
        result    = (op_cur == OP_NOR) ? ~acc_next : acc_next;

        acc_d       = acc_q;
        beat_cnt_d  = beat_cnt_q;
        first_d     = first_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        all_ones_d  = all_ones_q;
        all_zeros_d = all_zeros_q;
        out_beats_d = out_beats_q;
        overflow_d  = overflow_q;
        pop_d       = pop_q;

        if (accept) begin
            op_d = op_cur;
            if (close) begin
                acc_d      = '0;
                beat_cnt_d = '0;
                first_d    = 1'b1;
            end else begin
                acc_d      = acc_next;
                beat_cnt_d = beat_next;
                first_d    = 1'b0;
            end
        end

        // A new close wins over a drain in the same cycle, so no bubble appears.
        if (close) begin
            out_valid_d = 1'b1;
            out_data_d  = result;
            all_ones_d  = (result == {WIDTH{1'b1}});
            all_zeros_d = (result == '0);
            out_beats_d = beat_next;
            overflow_d  = ~in_last;
            pop_d       = '0;
            for (int i = 0; i < WIDTH; i++) begin
                pop_d = pop_d + PW'(result[i]);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            beat_cnt_q  <= '0;
            first_q     <= 1'b1;
            op_q        <= OP_OR;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            all_ones_q  <= 1'b0;
            all_zeros_q <= 1'b0;
            out_beats_q <= '0;
            overflow_q  <= 1'b0;
            pop_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            beat_cnt_q  <= beat_cnt_d;
            first_q     <= first_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            all_ones_q  <= all_ones_d;
            all_zeros_q <= all_zeros_d;
            out_beats_q <= out_beats_d;
            overflow_q  <= overflow_d;
            pop_q       <= pop_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_all_ones  = all_ones_q;
    assign out_all_zeros = all_zeros_q;
    assign out_beats     = out_beats_q;
    assign out_overflow  = overflow_q;

`ifdef BITWISE_ACCUM_POPCOUNT_EN
    assign out_popcount = pop_q;
`else
    logic unused_pop;
    assign unused_pop = ^pop_q;
`endif

endmodule
